cacheline_burst_adapter: RTL and testbench

CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

---
 rtl/cache_types_pkg.sv | 13 +
 rtl/line_shift_buffer.sv | 39 +++
 rtl/cacheline_burst_adapter.sv | 138 +++++++++++++
 tb/tb_cacheline_burst_adapter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types for the cache-line burst adapter: FSM state encoding and line geometry.
package cache_types_pkg;

    localparam int BEATS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adapter_state_e;

endpackage

// File: rtl/line_shift_buffer.sv
// Line storage: assembles read beats into line_o and serves beats of a latched write-back line.
// Beat writes land one cycle after beat_we_i; beat_o is combinational from the latched write line.
module line_shift_buffer #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [s_line-1:0]  line_i,
    input  logic               beat_we_i,
    input  logic [1:0]         beat_idx_i,
    input  logic [s_burst-1:0] beat_i,
    output logic [s_burst-1:0] beat_o,
    output logic [s_line-1:0]  line_o
);

    // Read assembly and write-back storage are kept apart so line_o survives write bursts.
    logic [s_line-1:0] rd_line_q;
    logic [s_line-1:0] wr_line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_line_q <= '0;
            wr_line_q <= '0;
        end else begin
            if (load_i) begin
                wr_line_q <= line_i;
            end
            if (beat_we_i) begin
                rd_line_q[int'(beat_idx_i)*s_burst +: s_burst] <= beat_i;
            end
        end
    end

    assign beat_o = wr_line_q[int'(beat_idx_i)*s_burst +: s_burst];
    assign line_o = rd_line_q;

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Converts cache line read/write requests into 4-beat memory bursts; resp_o pulses 1 + beats + 1 cycles after request.
// Memory paces each beat with resp_i; ADAPTER_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module cacheline_burst_adapter
    import cache_types_pkg::*;
#(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_offset = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [s_line-1:0]  line_i,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic [s_line-1:0]  line_o,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
`ifdef ADAPTER_PROTOCOL_CHECK_EN
    ,
    output logic               proto_err
`endif
);

    localparam logic [1:0]  LAST_BEAT = 2'(BEATS_PER_LINE - 1);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    adapter_state_e state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic           load;
    logic           beat_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        load    = 1'b0;
        beat_we = 1'b0;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        case (state_q)
            IDLE: begin
                // Write-back wins so a dirty victim is never lost behind a refill.
                if (write_i) begin
                    state_d = WR_BURST;
                    addr_d  = address_i;
                    load    = 1'b1;
                    cnt_d   = '0;
                end else if (read_i) begin
                    state_d = RD_BURST;
                    addr_d  = address_i;
                    cnt_d   = '0;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                write_o = 1'b1;
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign address_o = addr_q & ADDR_MASK;

    line_shift_buffer #(
        .s_line  (s_line),
        .s_burst (s_burst)
    ) u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .line_i     (line_i),
        .beat_we_i  (beat_we),
        .beat_idx_i (cnt_q),
        .beat_i     (burst_i),
        .beat_o     (burst_o),
        .line_o     (line_o)
    );

`ifdef ADAPTER_PROTOCOL_CHECK_EN
    logic proto_err_q;
    logic in_burst;

    assign in_burst = (state_q == RD_BURST) || (state_q == WR_BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
        end else if ((state_q == IDLE && read_i && write_i) ||
                     (in_burst && address_i != addr_q)) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized bench for cacheline_burst_adapter against a line/beat-level reference model.
module tb_cacheline_burst_adapter;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] line_i;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic [LW-1:0] line_o;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;
`ifdef ADAPTER_PROTOCOL_CHECK_EN
    logic          proto_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: line_o must show the last fully completed read line.
    logic [LW-1:0] last_line;

    always #5 clk = ~clk;

    cacheline_burst_adapter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
`ifdef ADAPTER_PROTOCOL_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) begin
            l[i*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    // One complete line transfer. data is the write-back line (write) or the line memory returns (read).
    // stall < 0 picks a random 0..3 cycle gap before each beat.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [LW-1:0] data, input int stall);
        bit            is_wr;
        int            gap;
        logic [BW-1:0] beat;
        is_wr = wr;
        @(negedge clk);
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = is_wr ? data : rand_line();
        resp_i    = 1'b0;
        @(negedge clk);
        check("rd_req_o", read_o, !is_wr);
        check("wr_req_o", write_o, is_wr);
        check("addr_o", address_o, {addr[31:5], 5'b0});
        for (int k = 0; k < NB; k++) begin
            beat = data[k*BW +: BW];
            gap  = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
            for (int s = 0; s < gap; s++) begin
                check("stall_resp_o", resp_o, 1'b0);
                check("stall_busy", is_wr ? write_o : read_o, 1'b1);
                if (is_wr) check("stall_burst_o", burst_o, beat);
                @(negedge clk);
            end
            if (is_wr) check("burst_o", burst_o, beat);
            check("beat_resp_o", resp_o, 1'b0);
            resp_i  = 1'b1;
            burst_i = is_wr ? BW'($urandom) : beat;
            @(negedge clk);
            resp_i  = 1'b0;
        end
        check("done_resp_o", resp_o, 1'b1);
        check("done_rd_o", read_o, 1'b0);
        check("done_wr_o", write_o, 1'b0);
        if (!is_wr) last_line = data;
        check("done_line_o", line_o, last_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
        check("idle_resp_o", resp_o, 1'b0);
        check("idle_busy", read_o | write_o, 1'b0);
        check("idle_line_o", line_o, last_line);
    endtask

    initial begin
        rst_n     = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        last_line = '0;
        #1;
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_line_o", line_o, '0);
        check("rst_addr_o", address_o, '0);
        check("rst_burst_o", burst_o, '0);
`ifdef ADAPTER_PROTOCOL_CHECK_EN
        check("rst_proto_err", proto_err, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(1'b1, 1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
        check("read_addr_1220", address_o, 32'h0000_1220);

        run_txn(1'b0, 1'b1, 32'h0000_8040,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0);

        // Stray acknowledges while idle must not advance anything.
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = BW'($urandom);
        @(negedge clk);
        check("stray_busy", read_o | write_o, 1'b0);
        check("stray_resp_o", resp_o, 1'b0);
        check("stray_line_o", line_o, last_line);
        resp_i = 1'b0;
        run_txn(1'b1, 1'b0, $urandom, rand_line(), 5);

        for (int t = 0; t < 24; t++) begin
            bit wr;
            wr = $urandom_range(1, 0) == 1;
            run_txn(!wr, wr, $urandom, rand_line(), -1);
        end

        // Reset in the middle of a read burst.
        @(negedge clk);
        read_i    = 1'b1;
        address_i = 32'hCAFE_0177;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            resp_i  = 1'b1;
            burst_i = BW'($urandom);
            @(negedge clk);
        end
        resp_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("abort_read_o", read_o, 1'b0);
        check("abort_resp_o", resp_o, 1'b0);
        check("abort_line_o", line_o, '0);
        check("abort_addr_o", address_o, '0);
        last_line = '0;
        read_i    = 1'b0;
        @(negedge clk);
        check("abort_no_resp", resp_o, 1'b0);
        rst_n = 1'b1;
        run_txn(1'b1, 1'b0, 32'h0000_2468, rand_line(), -1);

`ifdef ADAPTER_PROTOCOL_CHECK_EN
        check("pre_proto_err", proto_err, 1'b0);
`endif
        run_txn(1'b1, 1'b1, 32'h0000_3000, rand_line(), -1);
`ifdef ADAPTER_PROTOCOL_CHECK_EN
        check("both_proto_err", proto_err, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
